fib_seq: RTL and testbench
==========================

# fib_seq

Parametrised iterative Fibonacci-recurrence engine, the successor to the fixed 32-bit `main` kernel. It advances one recurrence step per clock instead of one per several states. It adds a configurable data width, modular and saturating arithmetic, and a sticky overflow flag. It reuses the existing load/launch convention: `r_enable` loads operands, and `w_enable`/`result` report completion. It sits behind the host interface as a drop-in compute kernel.

## Interface
- `W`, default 32: data width of operands, modulus and result.
- `NW`, default 6: width of the step count.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `r_enable` input 1: reset, synchronous and active-high; it also loads the `init_*` inputs. Operation starts on the first edge with `r_enable` low.
- `init_n` input NW: number of recurrence steps.
- `init_a` input W: initial term a.
- `init_b` input W: initial term b.
- `init_mod` input W: modulus. 0 means no modulus, so arithmetic is native W-bit.
- `sat_mode` input 1: applies only when `init_mod`==0. 1 saturates at all-ones; 0 wraps.
- `busy` output 1: high in RUN.
- `w_enable` output 1 (reg): result valid; held until the next `r_enable`.
- `result` output W (reg): final value of a.
- `overflow` output 1 (reg): sticky; set if any step exceeded 2^W−1 with `init_mod`==0.

## Operation
- Registers: `n` (NW bits), `a` (W bits), `b` (W bits), `mod` (W bits), `sat` (1 bit), state.
- States: RUN and DONE.
- `r_enable`=1 at an edge, from any state:
  - n, a, b, mod, sat load from the inputs; state goes to RUN.
  - `w_enable`, `overflow` and `result` clear to 0.
- RUN with n==0: `result`<=a, `w_enable`<=1, state goes to DONE.
- RUN with n!=0: the step is a<=b, b<=f(a+b), n<=n−1.
- The sum s=a+b is computed at W+1 bits. f(s) is selected as follows:
  - mod!=0: s−mod if s≥mod, else s. The result stays in [0,mod). `overflow` is never set.
  - mod==0, sat=0: s[W−1:0]. `overflow` is set if s[W]=1.
  - mod==0, sat=1: all-ones if s[W]=1, else s. `overflow` is set if s[W]=1.
- DONE holds `result`, `w_enable` and `overflow` stable. Only `r_enable` leaves DONE.
- `init_a` or `init_b` ≥ `init_mod` (with `init_mod`!=0) is unsupported; the result is unspecified and benches must not drive it.
- n is an unsigned count from 0 to 2^NW−1; there is no wrap because n stops at 0.

## Timing
- Reset values: `w_enable`=0, `result`=0, `overflow`=0, `busy`=1. The state is RUN as soon as the load is taken.
- Edge k is the k-th rising edge with `r_enable` low.
- Steps are performed on edges 1..n. `w_enable` and `result` update on edge n+1. Latency is n+1 cycles.
- `busy` is high from the load edge through edge n. It falls on the same edge that `w_enable` rises.
- Reset during RUN aborts immediately. No partial result is produced, and `w_enable` stays 0 until the new run completes.
- `r_enable` held high holds the block in the load state indefinitely; inputs are resampled every edge.
- Inputs other than `r_enable` are ignored while `r_enable` is low.

## Configuration
- `FIB_SEQ_STREAM_EN` defined: the block adds output ports `term_valid` (1 bit) and `term_data` (W bits).
  - `term_valid` is registered and pulses for one cycle after every step edge, carrying the new a.
  - Both ports reset to 0 on `r_enable`, and are 0 in DONE.
  - A run of n steps gives exactly n pulses on consecutive cycles.
- Macro undefined: neither port exists, and all other behaviour is identical.

## Test plan
- W=32, n=10, a=0, b=1, mod=0 → `w_enable` rises at edge 11, `result`=55, `overflow`=0.
- n=0, a=7, b=9 → `w_enable` rises at edge 1, `result`=7.
- W=8, n=14, a=0, b=1, mod=0, sat_mode=0 → `result`=121 (377 mod 256), `overflow`=1.
- W=8, n=14, a=0, b=1, mod=0, sat_mode=1 → `result`=255, `overflow`=1.
- W=32, n=20, a=0, b=1, mod=1000 → `result`=765, `overflow`=0.
- n=40 run, then `r_enable` pulsed at edge 5 with n=3, a=2, b=3 → `w_enable` stays 0 until edge 4 after release, then `result`=8. With `FIB_SEQ_STREAM_EN` defined, `term_data` is 3, 5, 8 on 3 consecutive cycles.

Source files
------------

// File: rtl/fib_seq.sv
// fib_seq: one-step-per-clock Fibonacci recurrence with modular, wrapping or saturating arithmetic.
// Optional streaming of intermediate terms is enabled by defining FIB_SEQ_STREAM_EN.
module fib_seq #(
    parameter int W  = 32,
    parameter int NW = 6
) (
    input  logic          clk,
    input  logic          r_enable,
    input  logic [NW-1:0] init_n,
    input  logic [W-1:0]  init_a,
    input  logic [W-1:0]  init_b,
    input  logic [W-1:0]  init_mod,
    input  logic          sat_mode,
    output logic          busy,
    output logic          w_enable,
    output logic [W-1:0]  result,
    output logic          overflow
`ifdef FIB_SEQ_STREAM_EN
    ,
    output logic          term_valid,
    output logic [W-1:0]  term_data
`endif
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_nextState;

    logic [NW-1:0] r_n;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_mod;
    logic          r_sat;

    logic          w_step;
    logic          w_finish;
    logic [W:0]    w_sum;
    logic [W:0]    w_modSub;
    logic [W-1:0]  w_nextTerm;
    logic          w_stepOvf;

    always_ff @(posedge clk) begin
        if (r_enable) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (r_state == ST_RUN && r_n == '0) begin
            w_nextState = ST_DONE;
        end
    end

    always_comb begin
        busy     = (r_state == ST_RUN);
        w_step   = (r_state == ST_RUN) && (r_n != '0);
        w_finish = (r_state == ST_RUN) && (r_n == '0);
    end

    // The sum is one bit wider so both the modular reduction and the overflow test see the true value.
    assign w_sum    = {1'b0, r_a} + {1'b0, r_b};
    assign w_modSub = w_sum - {1'b0, r_mod};

    always_comb begin
        w_nextTerm = w_sum[W-1:0];
        w_stepOvf  = 1'b0;
        if (r_mod != '0) begin
            if (w_sum >= {1'b0, r_mod}) begin
                w_nextTerm = w_modSub[W-1:0];
            end
        end else if (w_sum[W]) begin
            w_stepOvf = 1'b1;
            if (r_sat) begin
                w_nextTerm = '1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_enable) begin
            r_n      <= init_n;
            r_a      <= init_a;
            r_b      <= init_b;
            r_mod    <= init_mod;
            r_sat    <= sat_mode;
            result   <= '0;
            w_enable <= 1'b0;
            overflow <= 1'b0;
        end else if (w_step) begin
            r_a <= r_b;
            r_b <= w_nextTerm;
            r_n <= r_n - NW'(1);
            if (w_stepOvf) begin
                overflow <= 1'b1;
            end
        end else if (w_finish) begin
            result   <= r_a;
            w_enable <= 1'b1;
        end
    end

`ifdef FIB_SEQ_STREAM_EN
    // The new a after a step is the old b, so it is published directly.
    always_ff @(posedge clk) begin
        if (r_enable) begin
            term_valid <= 1'b0;
            term_data  <= '0;
        end else if (w_step) begin
            term_valid <= 1'b1;
            term_data  <= r_b;
        end else begin
            term_valid <= 1'b0;
            term_data  <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_fib_seq.sv
// Bench for fib_seq: a 32-bit and an 8-bit instance share stimulus and are checked every cycle
// against a step-count based arithmetic model; optional stream ports follow FIB_SEQ_STREAM_EN.
module tb_fib_seq;
    localparam int NW = 6;

    logic          clk = 1'b0;
    logic          r_enable = 1'b1;
    logic [NW-1:0] init_n = '0;
    logic [31:0]   init_a = '0;
    logic [31:0]   init_b = '0;
    logic [31:0]   init_mod = '0;
    logic          sat_mode = 1'b0;

    logic          busy32, we32, ovf32;
    logic [31:0]   res32;
    logic          busy8, we8, ovf8;
    logic [7:0]    res8;
`ifdef FIB_SEQ_STREAM_EN
    logic          tv32, tv8;
    logic [31:0]   td32;
    logic [7:0]    td8;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fib_seq #(.W(32), .NW(NW)) dut32 (
        .clk(clk), .r_enable(r_enable), .init_n(init_n), .init_a(init_a), .init_b(init_b),
        .init_mod(init_mod), .sat_mode(sat_mode), .busy(busy32), .w_enable(we32),
        .result(res32), .overflow(ovf32)
`ifdef FIB_SEQ_STREAM_EN
        , .term_valid(tv32), .term_data(td32)
`endif
    );

    fib_seq #(.W(8), .NW(NW)) dut8 (
        .clk(clk), .r_enable(r_enable), .init_n(init_n), .init_a(init_a[7:0]), .init_b(init_b[7:0]),
        .init_mod(init_mod[7:0]), .sat_mode(sat_mode), .busy(busy8), .w_enable(we8),
        .result(res8), .overflow(ovf8)
`ifdef FIB_SEQ_STREAM_EN
        , .term_valid(tv8), .term_data(td8)
`endif
    );

    // Plain arithmetic version of the recurrence: value of a after a given number of steps.
    function automatic void modelRun(input int w, input int steps, input longint a0, input longint b0,
                                     input longint mod0, input bit sat,
                                     output longint aOut, output bit ovf);
        longint mask, a, b, md, s, f;
        mask = (64'sd1 <<< w) - 1;
        a = a0 & mask;
        b = b0 & mask;
        md = mod0 & mask;
        ovf = 1'b0;
        for (int i = 0; i < steps; i++) begin
            s = a + b;
            if (md != 0) begin
                f = (s >= md) ? s - md : s;
            end else if (s > mask) begin
                ovf = 1'b1;
                f = sat ? mask : (s & mask);
            end else begin
                f = s;
            end
            a = b;
            b = f;
        end
        aOut = a;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model state: loaded configuration and edges elapsed since the last load edge.
    bit     mValid = 1'b0;
    int     mK = 0;
    int     mN = 0;
    longint mA, mB, mMod;
    bit     mSat;

    always @(posedge clk) begin
        if (r_enable) begin
            mValid = 1'b1;
            mK   = 0;
            mN   = int'(init_n);
            mA   = longint'(init_a);
            mB   = longint'(init_b);
            mMod = longint'(init_mod);
            mSat = sat_mode;
        end else if (mValid) begin
            mK++;
        end
    end

    task automatic checkInst(input string tag, input int w, input logic busyA, input logic weA,
                             input logic [63:0] resA, input logic ovfA,
                             input logic tvA, input logic [63:0] tdA, input bit haveStream);
        longint aK;
        bit     ovfK, done;
        int     stepsDone;
        stepsDone = (mK < mN) ? mK : mN;
        modelRun(w, stepsDone, mA, mB, mMod, mSat, aK, ovfK);
        done = (mK > mN);
        checkOutput({tag, "_busy"}, busyA, !done);
        checkOutput({tag, "_w_enable"}, weA, done);
        checkOutput({tag, "_result"}, resA, done ? aK : 0);
        checkOutput({tag, "_overflow"}, ovfA, ovfK);
        if (haveStream) begin
            checkOutput({tag, "_term_valid"}, tvA, (!done && mK >= 1));
            checkOutput({tag, "_term_data"}, tdA, (!done && mK >= 1) ? aK : 0);
        end
    endtask

    always @(negedge clk) begin
        if (mValid) begin
`ifdef FIB_SEQ_STREAM_EN
            checkInst("w32", 32, busy32, we32, 64'(res32), ovf32, tv32, 64'(td32), 1'b1);
            checkInst("w8", 8, busy8, we8, 64'(res8), ovf8, tv8, 64'(td8), 1'b1);
`else
            checkInst("w32", 32, busy32, we32, 64'(res32), ovf32, 1'b0, 64'd0, 1'b0);
            checkInst("w8", 8, busy8, we8, 64'(res8), ovf8, 1'b0, 64'd0, 1'b0);
`endif
        end
    end

    // Loads a configuration through one r_enable edge, checks the reset-state outputs, releases.
    task automatic applyStimulus(input int n, input longint a, input longint b, input longint md, input bit sat);
        @(negedge clk);
        #1;
        r_enable = 1'b1;
        init_n   = NW'(n);
        init_a   = 32'(a);
        init_b   = 32'(b);
        init_mod = 32'(md);
        sat_mode = sat;
        @(negedge clk);
        checkOutput("rst_busy", busy32, 1);
        checkOutput("rst_w_enable", we32, 0);
        checkOutput("rst_result", res32, 0);
        checkOutput("rst_overflow", ovf8, 0);
        #1;
        r_enable = 1'b0;
        init_n   = NW'(17);
        init_a   = 32'd12345;
        init_b   = 32'd999;
        init_mod = 32'd0;
        sat_mode = ~sat;
    endtask

    task automatic runAndCheck(input string name, input int n, input longint a, input longint b,
                               input longint md, input bit sat,
                               input longint exp32, input bit expOvf32, input longint exp8, input bit expOvf8);
        int cnt;
        applyStimulus(n, a, b, md, sat);
        cnt = 0;
        while (we32 !== 1'b1 && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput({name, "_latency"}, cnt, n + 1);
        checkOutput({name, "_res32"}, res32, exp32);
        checkOutput({name, "_ovf32"}, ovf32, expOvf32);
        checkOutput({name, "_res8"}, res8, exp8);
        checkOutput({name, "_ovf8"}, ovf8, expOvf8);
        repeat (3) @(negedge clk);
        checkOutput({name, "_hold_we"}, we8, 1);
        checkOutput({name, "_hold_res32"}, res32, exp32);
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin : main
        longint pa;
        bit     po;
        int     cnt;
        longint terms[$];

        modelRun(32, 10, 0, 1, 0, 0, pa, po);
        checkOutput("model_fib10", pa, 55);
        modelRun(8, 14, 0, 1, 0, 0, pa, po);
        checkOutput("model_w8_wrap", pa, 121);
        checkOutput("model_w8_wrap_ovf", po, 1);
        modelRun(8, 14, 0, 1, 0, 1, pa, po);
        checkOutput("model_w8_sat", pa, 255);
        modelRun(32, 20, 0, 1, 1000, 0, pa, po);
        checkOutput("model_mod1000", pa, 765);

        repeat (2) @(negedge clk);

        runAndCheck("fib10", 10, 0, 1, 0, 0, 55, 0, 55, 0);
        runAndCheck("n0", 0, 7, 9, 0, 0, 7, 0, 7, 0);
        runAndCheck("wrap14", 14, 0, 1, 0, 0, 377, 0, 121, 1);
        runAndCheck("sat14", 14, 0, 1, 0, 1, 377, 0, 255, 1);
        runAndCheck("mod1000", 20, 0, 1, 1000, 0, 765, 0, 37, 0);
        runAndCheck("nmax_sat", 63, 0, 1, 0, 1, 64'hFFFF_FFFF, 1, 255, 1);

        // Held load with changing inputs: only the last sampled values count.
        @(negedge clk);
        #1;
        r_enable = 1'b1;
        init_n   = NW'(40);
        init_a   = 32'd5;
        init_b   = 32'd6;
        repeat (3) @(negedge clk);
        runAndCheck("held", 10, 0, 1, 0, 0, 55, 0, 55, 0);

        // Abort a long run at edge 5 and restart with n=3, a=2, b=3.
        applyStimulus(40, 0, 1, 0, 0);
        repeat (4) @(negedge clk);
        checkOutput("abort_pre_we", we32, 0);
        #1;
        r_enable = 1'b1;
        init_n   = NW'(3);
        init_a   = 32'd2;
        init_b   = 32'd3;
        init_mod = 32'd0;
        sat_mode = 1'b0;
        @(negedge clk);
        checkOutput("abort_rst_we", we32, 0);
        #1;
        r_enable = 1'b0;
        cnt = 0;
        while (we32 !== 1'b1 && cnt < 300) begin
            @(negedge clk);
            cnt++;
`ifdef FIB_SEQ_STREAM_EN
            if (tv32 === 1'b1) terms.push_back(longint'(td32));
`endif
        end
        checkOutput("abort_latency", cnt, 4);
        checkOutput("abort_result", res32, 8);
`ifdef FIB_SEQ_STREAM_EN
        checkOutput("abort_nterms", terms.size(), 3);
        if (terms.size() == 3) begin
            checkOutput("abort_term0", terms[0], 3);
            checkOutput("abort_term1", terms[1], 5);
            checkOutput("abort_term2", terms[2], 8);
        end
`endif
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
